// File: rtl/smac_drain.sv
// Result collector for the smac column: tracks issued operations through the pipeline,
// lane-masks each result as it emerges and queues it in a first-word-fall-through FIFO.
module smac_drain #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         sclr,
    input  logic                         ce,
    input  logic                         issue,
    input  logic [3:0]                   select_precision,
    input  logic [63:0]                  res_mac_n,
    output logic                         m_valid,
    output logic [63:0]                  m_data,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic [$clog2(LATENCY):0]     inflight,
    output logic                         stall_req,
    output logic                         overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(LATENCY) + 1;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [3:0]         mask_q [LATENCY];
    logic [3:0]         mask_d [LATENCY];
    logic [63:0]        mem_q  [DEPTH];
    logic [63:0]        mem_d  [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;

    logic               push, pop, full, accept;
    logic [3:0]         out_mask;
    logic [63:0]        lane_mask, push_word;

    always_comb begin
        push      = ce & vld_q[LATENCY-1];
        m_valid   = (count_q != '0);
        pop       = m_valid & m_ready;
        full      = (count_q == CW'(DEPTH));
        accept    = push & (~full | pop);
        out_mask  = mask_q[LATENCY-1];
        lane_mask = {{32{out_mask[3]}}, {16{out_mask[2]}}, {8{out_mask[1]}}, {8{out_mask[0]}}};
        push_word = res_mac_n & lane_mask;
    end

    // Token and mask pipes hold with ce low, mirroring the DSP clock-enable.
    always_comb begin
        vld_d  = vld_q;
        mask_d = mask_q;
        if (ce) begin
            vld_d     = {vld_q[LATENCY-2:0], issue};
            mask_d[0] = select_precision;
            for (int i = 1; i < int'(LATENCY); i++) begin
                mask_d[i] = mask_q[i-1];
            end
        end
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push & ~accept);
        if (accept) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                mask_q[i] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            mask_q     <= mask_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: m_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
        count     = count_q;
        inflight  = IW'($countones(vld_q));
        overflow  = overflow_q;
        stall_req = (int'(count_q) + int'(inflight)) >= int'(DEPTH);
    end

endmodule

// File: tb/tb_smac_drain.sv
// Directed bench for smac_drain: a cycle table for latency/masking, plus hand sequences
// for ce stalls, FIFO full/overflow, full push+pop and mid-flight reset.
module tb_smac_drain;

    logic        clk = 1'b0;
    logic        sclr, ce, issue, m_ready;
    logic [3:0]  sel;
    logic [63:0] res;
    logic        m_valid, stall_req, overflow;
    logic [63:0] m_data;
    logic [3:0]  count;
    logic [2:0]  inflight;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] p0, p1, p2;

    always #5 clk = ~clk;

    smac_drain #(.LATENCY(3), .DEPTH(8)) dut (
        .clk              (clk),
        .sclr             (sclr),
        .ce               (ce),
        .issue            (issue),
        .select_precision (sel),
        .res_mac_n        (res),
        .m_valid          (m_valid),
        .m_data           (m_data),
        .m_ready          (m_ready),
        .count            (count),
        .inflight         (inflight),
        .stall_req        (stall_req),
        .overflow         (overflow)
    );

    typedef struct {
        bit          ce;
        bit          iss;
        logic [3:0]  sel;
        logic [63:0] res;
        bit          rdy;
        bit          v;
        logic [63:0] d;
        int          c;
        int          inf;
        bit          st;
        bit          ov;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit v, input logic [63:0] d, input int c,
                           input int inf, input bit st, input bit ov);
        chk({tag, ".m_valid"},   64'(m_valid),   64'(v));
        chk({tag, ".m_data"},    m_data,         d);
        chk({tag, ".count"},     64'(count),     64'(c));
        chk({tag, ".inflight"},  64'(inflight),  64'(inf));
        chk({tag, ".stall_req"}, 64'(stall_req), 64'(st));
        chk({tag, ".overflow"},  64'(overflow),  64'(ov));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sclr = 1'b1; ce = 1'b0; issue = 1'b0; m_ready = 1'b0; sel = 4'h0; res = '0;
        step();
        sclr = 1'b0;
        p0 = '0; p1 = '0; p2 = '0;
    endtask

    // One ce=1 cycle; res_mac_n carries the value of the token issued three cycles earlier.
    task automatic tick(input bit iss, input logic [63:0] v, input bit rdy);
        ce = 1'b1; issue = iss; sel = 4'hF; res = p2; m_ready = rdy;
        step();
        p2 = p1; p1 = p0; p0 = iss ? v : 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    initial begin
        //         ce iss sel   res                     rdy  v  d                       c inf st ov
        tbl[0]  = '{1, 1, 4'hF, 64'h0,                   0,  0, 64'h0,                  0, 1, 0, 0};
        tbl[1]  = '{1, 1, 4'h1, 64'h0,                   0,  0, 64'h0,                  0, 2, 0, 0};
        tbl[2]  = '{1, 1, 4'hC, 64'h0,                   0,  0, 64'h0,                  0, 3, 0, 0};
        tbl[3]  = '{1, 0, 4'h0, 64'h0123_4567_89AB_CDEF, 0,  1, 64'h0123_4567_89AB_CDEF, 1, 2, 0, 0};
        tbl[4]  = '{1, 0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  1, 64'h0123_4567_89AB_CDEF, 2, 1, 0, 0};
        tbl[5]  = '{1, 0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  1, 64'h0123_4567_89AB_CDEF, 3, 0, 0, 0};
        tbl[6]  = '{1, 0, 4'h0, 64'h0,                   1,  1, 64'h0000_0000_0000_00FF, 2, 0, 0, 0};
        tbl[7]  = '{1, 0, 4'h0, 64'h0,                   1,  1, 64'hFFFF_FFFF_FFFF_0000, 1, 0, 0, 0};
        tbl[8]  = '{1, 0, 4'h0, 64'h0,                   1,  0, 64'h0,                  0, 0, 0, 0};
        tbl[9]  = '{1, 1, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  0, 64'h0,                  0, 1, 0, 0};
        tbl[10] = '{1, 0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  0, 64'h0,                  0, 1, 0, 0};
        tbl[11] = '{1, 0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  0, 64'h0,                  0, 1, 0, 0};
        tbl[12] = '{1, 0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  1, 64'h0,                  1, 0, 0, 0};
        tbl[13] = '{1, 0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1,  0, 64'h0,                  0, 0, 0, 0};

        // Reset state
        sclr = 1'b1; ce = 1'b1; issue = 1'b1; m_ready = 1'b1; sel = 4'hF; res = '1;
        step();
        step();
        chk_all("reset", 0, 64'h0, 0, 0, 0, 0);
        do_reset();

        // Latency, masking and zero-mask push
        for (int i = 0; i < 14; i++) begin
            ce = tbl[i].ce; issue = tbl[i].iss; sel = tbl[i].sel;
            res = tbl[i].res; m_ready = tbl[i].rdy;
            step();
            chk_all($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].inf,
                    tbl[i].st, tbl[i].ov);
        end

        // ce stall after the first shift: no push, held issue ignored, stalled res not captured
        do_reset();
        ce = 1'b1; issue = 1'b1; sel = 4'hF; res = '0;
        step();
        chk("stall.inflight0", 64'(inflight), 64'd1);
        issue = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            ce = 1'b0; issue = 1'b1; res = 64'hAAAA_AAAA_AAAA_AAAA ^ 64'(i);
            step();
            chk($sformatf("stall.hold%0d.count", i), 64'(count), 64'd0);
            chk($sformatf("stall.hold%0d.inflight", i), 64'(inflight), 64'd1);
        end
        ce = 1'b1; issue = 1'b0; res = 64'h1111_1111_1111_1111;
        step();
        chk("stall.e2.count", 64'(count), 64'd0);
        res = 64'h2222_2222_2222_2222;
        step();
        chk_all("stall.push", 1, 64'h2222_2222_2222_2222, 1, 0, 0, 0);
        ce = 1'b0; m_ready = 1'b1;
        step();
        chk("stall.pop_while_ce0", 64'(count), 64'd0);

        // Full / overflow with issue ignoring stall_req
        do_reset();
        for (int c = 0; c < 15; c++) begin
            int n, p, inf, cnt;
            tick(c < 11, 64'(c + 1), 1'b0);
            n   = (c + 1 < 11) ? c + 1 : 11;
            p   = (c - 2 < 0) ? 0 : ((c - 2 > 11) ? 11 : c - 2);
            inf = n - p;
            cnt = (p > 8) ? 8 : p;
            chk($sformatf("full.c%0d.count", c), 64'(count), 64'(cnt));
            chk($sformatf("full.c%0d.inflight", c), 64'(inflight), 64'(inf));
            chk($sformatf("full.c%0d.stall", c), 64'(stall_req), 64'(cnt + inf >= 8));
            chk($sformatf("full.c%0d.overflow", c), 64'(overflow), 64'(p > 8));
        end
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d.valid", i), 64'(m_valid), 64'd1);
            chk($sformatf("drain%0d.data", i), m_data, 64'(i));
            tick(1'b0, '0, 1'b1);
        end
        chk_all("drain.end", 0, 64'h0, 0, 0, 0, 1);

        // Full with simultaneous push and pop across pointer wrap
        do_reset();
        for (int i = 0; i < 9; i++) tick(1'b1, 64'(200 + i), 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        chk("pp.pre.count", 64'(count), 64'd8);
        chk("pp.pre.head", m_data, 64'd200);
        tick(1'b0, '0, 1'b1);
        chk_all("pp.same", 1, 64'd201, 8, 0, 1, 0);
        for (int i = 201; i <= 208; i++) begin
            chk($sformatf("pp.drain%0d", i), m_data, 64'(i));
            tick(1'b0, '0, 1'b1);
        end
        chk_all("pp.end", 0, 64'h0, 0, 0, 0, 0);

        // Reset mid-flight
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 64'(300 + i), 1'b0);
        tick(1'b0, '0, 1'b0);
        chk("mid.count", 64'(count), 64'd3);
        chk("mid.inflight", 64'(inflight), 64'd2);
        sclr = 1'b1; ce = 1'b1; issue = 1'b1; m_ready = 1'b1; res = '1;
        step();
        sclr = 1'b0; issue = 1'b0; m_ready = 1'b0;
        chk_all("mid.after_sclr", 0, 64'h0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("mid.late%0d.count", i), 64'(count), 64'd0);
            chk($sformatf("mid.late%0d.valid", i), 64'(m_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
